// File: rtl/afe_roic_pkg.sv
// Shared constants, state encoding and LFSR helper for the ROIC stream generator.
package afe_roic_pkg;

    localparam logic [4:0] PAT_NORMAL = 5'h00;
    localparam logic [4:0] PAT_FIXED  = 5'h11;
    localparam logic [4:0] PAT_RAMP   = 5'h13;
    localparam logic [4:0] PAT_ZEROS  = 5'h17;
    localparam logic [4:0] PAT_ONES   = 5'h19;
    localparam logic [4:0] PAT_DESKEW = 5'h1E;

    localparam logic [7:0] ADDR_RESET        = 8'h00;
    localparam logic [7:0] ADDR_TEST_PATTERN = 8'h10;
    localparam logic [7:0] ADDR_POWER_DOWN   = 8'h13;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    // One step of the right-shifting Galois LFSR.
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
    endfunction

endpackage

// File: rtl/afe_roic_stream_gen_if.sv
// Register-write bus from the SPI decoder into the stream generator.
interface afe_roic_stream_gen_if;

    logic        we;
    logic [7:0]  addr;
    logic [15:0] wdata;

    modport master (output we, addr, wdata);
    modport slave  (input  we, addr, wdata);

endinterface

// File: rtl/afe_roic_word_gen.sv
// Combinational builder of one lane's {header, pixel} word.
module afe_roic_word_gen
    import afe_roic_pkg::*;
#(
    parameter int          PIXEL_WIDTH   = 16,
    parameter int          HEADER_WIDTH  = 8,
    parameter logic [15:0] FIXED_PATTERN = 16'hAAAA
) (
    input  logic [4:0]                          i_pattern,
    input  logic [15:0]                         i_ch,
    input  logic [15:0]                         i_pix_idx,
    input  logic [15:0]                         i_lfsr,
    output logic [HEADER_WIDTH+PIXEL_WIDTH-1:0] o_word
);

    localparam int HH = HEADER_WIDTH / 2;

    logic [31:0]            w_ramp;
    logic [PIXEL_WIDTH-1:0] w_pixel;

    // Ramp is computed wide and wrapped to the pixel width.
    assign w_ramp = 32'(i_pix_idx) + (32'(i_ch) << 8);

    // Pixel value selected by the pattern code; unknown codes send zeros.
    always_comb begin
        w_pixel = '0;
        case (i_pattern)
            PAT_NORMAL: w_pixel = PIXEL_WIDTH'(32'(i_lfsr ^ i_ch));
            PAT_FIXED:  w_pixel = PIXEL_WIDTH'(32'(FIXED_PATTERN));
            PAT_RAMP:   w_pixel = PIXEL_WIDTH'(w_ramp);
            PAT_ZEROS:  w_pixel = '0;
            PAT_ONES:   w_pixel = '1;
            PAT_DESKEW: w_pixel = {{(PIXEL_WIDTH-4){1'b1}}, 4'b0000};
            default:    w_pixel = '0;
        endcase
    end

    assign o_word = {i_ch[HH-1:0], i_pix_idx[HH-1:0], w_pixel};

endmodule

// File: rtl/afe_roic_stream_gen.sv
// Frame-triggered serial pixel stream generator emulating a ROIC output port.
//
// state | meaning
// IDLE  | waiting for a sync rising edge (ignored while asleep)
// LOAD  | latch active pattern, build word 0 of every lane
// SHIFT | shift words MSB first, reload next word with no bubble
// DONE  | one-cycle frame_done pulse, then back to IDLE
module afe_roic_stream_gen
    import afe_roic_pkg::*;
#(
    parameter int          NUM_CHANNELS       = 14,
    parameter int          PIXEL_WIDTH        = 16,
    parameter int          HEADER_WIDTH       = 8,
    parameter int          PIXELS_PER_CHANNEL = 256,
    parameter logic [15:0] FIXED_PATTERN      = 16'hAAAA
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sync_i,
    afe_roic_stream_gen_if.slave    cfg,
    output logic [NUM_CHANNELS-1:0] dout_o,
    output logic                    fclk_o,
    output logic                    busy_o,
    output logic                    frame_done_o,
    output logic                    sleep_o,
    output logic [7:0]              overrun_cnt_o
);

    localparam int WORD_W = HEADER_WIDTH + PIXEL_WIDTH;
    localparam int BIT_W  = $clog2(WORD_W);
    localparam int PIX_W  = $clog2(PIXELS_PER_CHANNEL);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_sync_q;
    logic [4:0]          r_pat_shadow;
    logic [4:0]          r_pat_active;
    logic                r_sleep;
    logic [15:0]         r_lfsr;
    logic [PIX_W-1:0]    r_pix_idx;
    logic [BIT_W-1:0]    r_bit_idx;
    logic [7:0]          r_overrun;
    logic [WORD_W-1:0]   r_shift [NUM_CHANNELS];
    logic [WORD_W-1:0]   w_word  [NUM_CHANNELS];

    logic        w_edge;
    logic        w_wr_reset;
    logic        w_wr_pat;
    logic        w_wr_pd;
    logic        w_sleep_val;
    logic        w_abort;
    logic        w_last_bit;
    logic        w_last_pix;
    logic [4:0]  w_build_pat;
    logic [15:0] w_build_pix;
    logic        w_cfg_unused;

    assign w_edge       = sync_i & ~r_sync_q;
    assign w_wr_reset   = cfg.we && (cfg.addr == ADDR_RESET) && cfg.wdata[0];
    assign w_wr_pat     = cfg.we && (cfg.addr == ADDR_TEST_PATTERN);
    assign w_wr_pd      = cfg.we && (cfg.addr == ADDR_POWER_DOWN);
    assign w_sleep_val  = (cfg.wdata[15:5] == 11'h7FF);
    assign w_abort      = w_wr_reset || (w_wr_pd && w_sleep_val);
    assign w_last_bit   = (r_bit_idx == '0);
    assign w_last_pix   = (r_pix_idx == PIX_W'(PIXELS_PER_CHANNEL - 1));
    assign w_cfg_unused = ^cfg.wdata[4:1];

    // Word 0 is built from the shadow so a write landing on LOAD misses this frame.
    assign w_build_pat = (r_state == LOAD) ? r_pat_shadow : r_pat_active;
    assign w_build_pix = (r_state == LOAD) ? 16'd0 : 16'(r_pix_idx) + 16'd1;

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_lane
        afe_roic_word_gen #(
            .PIXEL_WIDTH   (PIXEL_WIDTH),
            .HEADER_WIDTH  (HEADER_WIDTH),
            .FIXED_PATTERN (FIXED_PATTERN)
        ) u_word_gen (
            .i_pattern (w_build_pat),
            .i_ch      (16'(g)),
            .i_pix_idx (w_build_pix),
            .i_lfsr    (r_lfsr),
            .o_word    (w_word[g])
        );
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state decode and frame outputs; soft reset or sleep aborts from any state.
    always_comb begin
        w_state_nxt  = r_state;
        busy_o       = 1'b0;
        frame_done_o = 1'b0;
        fclk_o       = 1'b0;
        dout_o       = '0;
        case (r_state)
            IDLE:  if (w_edge && !r_sleep) w_state_nxt = LOAD;
            LOAD: begin
                busy_o      = 1'b1;
                w_state_nxt = SHIFT;
            end
            SHIFT: begin
                busy_o = 1'b1;
                fclk_o = (r_bit_idx >= BIT_W'(WORD_W / 2));
                for (int c = 0; c < NUM_CHANNELS; c++) dout_o[c] = r_shift[c][WORD_W-1];
                if (w_last_bit && w_last_pix) w_state_nxt = DONE;
            end
            DONE: begin
                frame_done_o = 1'b1;
                w_state_nxt  = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
        if (w_abort) w_state_nxt = IDLE;
    end

    // Config shadows, overrun counter, LFSR and per-lane shift registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync_q     <= 1'b0;
            r_pat_shadow <= PAT_NORMAL;
            r_pat_active <= PAT_NORMAL;
            r_sleep      <= 1'b0;
            r_lfsr       <= LFSR_SEED;
            r_pix_idx    <= '0;
            r_bit_idx    <= '0;
            r_overrun    <= '0;
            for (int c = 0; c < NUM_CHANNELS; c++) r_shift[c] <= '0;
        end else begin
            r_sync_q <= sync_i;
            if (w_edge && (r_state != IDLE) && (r_overrun != 8'hFF))
                r_overrun <= r_overrun + 8'd1;
            if (w_wr_pat) r_pat_shadow <= cfg.wdata[9:5];
            if (w_wr_pd)  r_sleep      <= w_sleep_val;
            if (w_wr_reset) begin
                r_pat_shadow <= PAT_NORMAL;
                r_sleep      <= 1'b0;
            end
            case (r_state)
                LOAD: begin
                    r_pat_active <= r_pat_shadow;
                    r_pix_idx    <= '0;
                    r_bit_idx    <= BIT_W'(WORD_W - 1);
                    r_lfsr       <= lfsr_next(r_lfsr);
                    for (int c = 0; c < NUM_CHANNELS; c++) r_shift[c] <= w_word[c];
                end
                SHIFT: begin
                    if (!w_last_bit) begin
                        r_bit_idx <= r_bit_idx - BIT_W'(1);
                        for (int c = 0; c < NUM_CHANNELS; c++) r_shift[c] <= r_shift[c] << 1;
                    end else if (!w_last_pix) begin
                        r_pix_idx <= r_pix_idx + PIX_W'(1);
                        r_bit_idx <= BIT_W'(WORD_W - 1);
                        r_lfsr    <= lfsr_next(r_lfsr);
                        for (int c = 0; c < NUM_CHANNELS; c++) r_shift[c] <= w_word[c];
                    end
                end
                default: ;
            endcase
        end
    end

    assign sleep_o       = r_sleep;
    assign overrun_cnt_o = r_overrun;

endmodule

// File: doc/afe_roic_stream_gen.md
Name: afe_roic_stream_gen

Overview:
Synthesizable, parametrised successor of the AFE2256 behavioural ROIC model, for FPGA loop-back and emulation builds. On each SYNC it emits one frame of per-channel serial pixel words (header + pixel data, MSB first, one bit per clk) with a word-framing FCLK. Its register-write port programs test patterns and power-down. Sits between the SPI-decode logic and the LVDS deserializer/aligner under test.

Parameters:
NUM_CHANNELS, 14, number of serial data lanes (1..32)
PIXEL_WIDTH, 16, ADC data bits per pixel (12..24)
HEADER_WIDTH, 8, header bits prepended to each pixel (even, 4..16)
PIXELS_PER_CHANNEL, 256, pixel words per channel per frame (2..4096)
FIXED_PATTERN, 16'hAAAA, value used by the fixed pattern, truncated/zero-extended to PIXEL_WIDTH

Ports:
clk  in  1  bit clock; one serial bit per cycle
rst  in  1  synchronous, active-high reset
sync_i  in  1  frame trigger, already synchronous to clk; rising edge starts a frame
cfg_we  in  1  register write strobe, single cycle
cfg_addr  in  8  register address
cfg_wdata  in  16  register data
dout_o  out  NUM_CHANNELS  serial data, one bit per lane
fclk_o  out  1  high for the first WORD_W/2 bits of every word
busy_o  out  1  high while a frame is being shifted
frame_done_o  out  1  one-cycle pulse after the last bit of a frame
sleep_o  out  1  power-down state
overrun_cnt_o  out  8  saturating count of ignored sync edges

Behaviour:
- WORD_W = HEADER_WIDTH + PIXEL_WIDTH. Word = {header, pixel}, sent MSB first.
- Header = {ch[HEADER_WIDTH/2-1:0], pix_idx[HEADER_WIDTH/2-1:0]}.
- Reset: all outputs 0. State IDLE. Shadow pattern = NORMAL. Not asleep. LFSR = 16'hACE1. Counters 0.
- Registers (shadow, written on cfg_we):
  - 0x00, bit0 = soft reset: abort the frame, go to IDLE, pattern NORMAL, sleep cleared. overrun_cnt is kept.
  - 0x10, pattern code = data[9:5]:
    - 0x00 NORMAL: 16-bit Galois LFSR (taps 0xB400) XOR ch, stepped once per word, truncated/extended to PIXEL_WIDTH.
    - 0x11 FIXED: FIXED_PATTERN.
    - 0x13 RAMP: pix_idx + (ch<<8), modulo 2^PIXEL_WIDTH.
    - 0x17 ZEROS.
    - 0x19 ONES.
    - 0x1E DESKEW: upper PIXEL_WIDTH-4 bits 1, lower 4 bits 0.
    - Any other code: ZEROS.
  - 0x13: sleep = (data[15:5] == 11'h7FF), else awake. Takes effect immediately.
  - All other addresses: ignored.
- Pattern shadow is copied to the active pattern only in LOAD.
  - A write during a frame affects the next frame only.
  - A write in the same cycle as LOAD: the frame uses the old value.
- sync edge detection: sync_q is a registered copy; edge = sync_i & ~sync_q.
- FSM:
  - IDLE: on edge with !sleep -> LOAD.
  - LOAD: 1 cycle. Latch the active pattern, build the word-0 shift registers, pix_idx = 0, busy_o = 1.
  - SHIFT: bit_idx counts WORD_W-1 down to 0 and dout_o = shift MSB.
    - At bit_idx == 0 and pix_idx < PIXELS_PER_CHANNEL-1: reload the next word with no bubble, pix_idx++.
    - At bit_idx == 0 and pix_idx == PIXELS_PER_CHANNEL-1: -> DONE.
  - DONE: 1 cycle. frame_done_o = 1, busy_o = 0, dout_o = 0 -> IDLE.
- Latency: edge sampled at cycle N -> LOAD at N+1 -> first bit on dout_o at N+2. Frame length = PIXELS_PER_CHANNEL*WORD_W SHIFT cycles.
- fclk_o = 1 when bit_idx >= WORD_W/2 in SHIFT, else 0.
- dout_o = 0 outside SHIFT.
- Edge in LOAD, SHIFT or DONE: ignored; overrun_cnt increments, saturating at 255.
- Edge while asleep: ignored, not counted.
- Sleep written mid-frame: abort the frame, return to IDLE, no frame_done pulse.
- rst mid-frame: next cycle everything is at reset values.

Decomposition:
- Package afe_roic_pkg:
  - Pattern-code localparams (PAT_NORMAL=5'h00, PAT_FIXED=5'h11, PAT_RAMP=5'h13, PAT_ZEROS=5'h17, PAT_ONES=5'h19, PAT_DESKEW=5'h1E).
  - Register addresses (ADDR_RESET=8'h00, ADDR_TEST_PATTERN=8'h10, ADDR_POWER_DOWN=8'h13).
  - State enum state_t {IDLE, LOAD, SHIFT, DONE}.
  - LFSR seed/taps constants.
- One sub-module, afe_roic_word_gen: combinational word builder for a single lane from pattern, ch, pix_idx and lfsr. Instantiated NUM_CHANNELS times in a generate loop.

Test Plan:
- Params NUM_CHANNELS=4, PIXELS_PER_CHANNEL=4, defaults otherwise. Write 0x10 with data[9:5]=0x13, pulse sync.
  - -> first bit 2 cycles after the edge cycle.
  - -> lane 2, pixel 3 word = 24'h23_0203.
  - -> frame_done_o exactly 96 SHIFT cycles later, busy_o low on the DONE cycle.
- Pattern 0x1E, one frame.
  - -> every lane every word low 16 bits = 16'hFFF0.
  - -> fclk_o high 12 cycles, low 12 cycles per word.
- Pattern 0x19 set, then 0x17 written mid-frame.
  - -> current frame all pixel bits 1.
  - -> next frame pixel bits 0, headers unchanged.
- Three sync edges during an active frame.
  - -> overrun_cnt_o = 3 and the frame completes unaffected.
  - -> 300 such edges saturate at 255.
- Write 0x13 data=16'hFFE0 mid-frame.
  - -> sleep_o = 1, return to IDLE, no frame_done_o.
  - -> later sync is ignored and not counted.
  - -> write 0x0000, then sync starts a frame.
- Assert rst during SHIFT.
  - -> next cycle all outputs 0 and overrun_cnt_o = 0.
  - -> NORMAL-pattern lane 0, pixel 0 = 16'hACE1 after the next frame.
